// File: rtl/nh_cpu_pkg.sv
// rtl/nh_cpu_pkg.sv - shared datapath widths and types for the NH CPU
package nh_cpu_pkg;
  localparam int unsigned ADDR_W = 2;
  localparam int unsigned DATA_W = 8;

  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0] reg_data_t;
endpackage

// File: rtl/reg_file_cell.sv
// rtl/reg_file_cell.sv - one register with async active-low clear and write enable
import nh_cpu_pkg::*;

module reg_file_cell #(
  parameter int unsigned DataBusWidth = DATA_W
) (
  input  logic                    clk,
  input  logic                    nRst,
  input  logic                    en,
  input  logic [DataBusWidth-1:0] d,
  output logic [DataBusWidth-1:0] q
);
  logic [DataBusWidth-1:0] r_q;

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      r_q <= '0;
    end else if (en) begin
      r_q <= d;
    end
  end

  assign q = r_q;
endmodule

// File: rtl/reg_file.sv
// rtl/reg_file.sv - 2**AddrBusWidth entry register file, two async read ports, one write port
import nh_cpu_pkg::*;

module reg_file #(
  parameter int unsigned AddrBusWidth = ADDR_W,
  parameter int unsigned DataBusWidth = DATA_W
) (
  input  logic                    clk,
  input  logic                    nRst,
  input  logic [AddrBusWidth-1:0] a1,
  input  logic [AddrBusWidth-1:0] a2,
  input  logic [AddrBusWidth-1:0] aWrite,
  input  logic [DataBusWidth-1:0] dataIn,
  input  logic                    load,
  output logic [DataBusWidth-1:0] out1,
  output logic [DataBusWidth-1:0] out2
);
  localparam int unsigned NREG = 2 ** AddrBusWidth;

  logic [DataBusWidth-1:0] w_regs [NREG];
  logic [NREG-1:0]         w_en;

  for (genvar i = 0; i < NREG; i++) begin : g_cell
    assign w_en[i] = load && (aWrite == AddrBusWidth'(i));

    reg_file_cell #(
      .DataBusWidth(DataBusWidth)
    ) u_cell (
      .clk  (clk),
      .nRst (nRst),
      .en   (w_en[i]),
      .d    (dataIn),
      .q    (w_regs[i])
    );
  end

  // No write bypass: reads see the stored value only.
  assign out1 = w_regs[a1];
  assign out2 = w_regs[a2];
endmodule

// File: tb/tb_reg_file.sv
// tb/tb_reg_file.sv - directed self-checking bench for reg_file
import nh_cpu_pkg::*;

module tb_reg_file;
  logic      clk = 1'b0;
  logic      nRst;
  reg_addr_t a1, a2, aWrite;
  reg_data_t dataIn;
  logic      load;
  reg_data_t out1, out2;

  typedef struct {
    string     tag;
    reg_data_t exp;
  } sb_t;

  sb_t       sb_q[$];
  reg_data_t model [4];
  int        total = 0;
  int        bad   = 0;

  always #10 clk = ~clk;

  reg_file dut (
    .clk    (clk),
    .nRst   (nRst),
    .a1     (a1),
    .a2     (a2),
    .aWrite (aWrite),
    .dataIn (dataIn),
    .load   (load),
    .out1   (out1),
    .out2   (out2)
  );

  task automatic push_exp(input string tag, input reg_data_t exp);
    sb_t e;
    e.tag = tag;
    e.exp = exp;
    sb_q.push_back(e);
  endtask

  task automatic pop_check(input reg_data_t obs);
    sb_t e;
    e = sb_q.pop_front();
    total++;
    assert (obs === e.exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
    end
  endtask

  task automatic sample(input string tag);
    push_exp({tag, "/out1"}, model[a1]);
    push_exp({tag, "/out2"}, model[a2]);
    #1;
    pop_check(out1);
    pop_check(out2);
  endtask

  task automatic sweep(input string tag);
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        a1 = reg_addr_t'(i);
        a2 = reg_addr_t'(j);
        sample($sformatf("%s_a%0d_%0d", tag, i, j));
      end
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 4; i++) model[i] = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    nRst = 1'b0; load = 1'b0; a1 = 2'd1; a2 = 2'd2; aWrite = '0; dataIn = '0;
    clear_model();
    #5;
    sample("por");
    @(negedge clk); nRst = 1'b1;

    // Preload two registers so the reset pulse has something to clear.
    @(negedge clk); aWrite = 2'd1; dataIn = 8'h5A; load = 1'b1;
    @(posedge clk); model[1] = 8'h5A;
    @(negedge clk); aWrite = 2'd2; dataIn = 8'hA5;
    @(posedge clk); model[2] = 8'hA5;
    @(negedge clk); load = 1'b0; a1 = 2'd1; a2 = 2'd2;
    sample("preload");

    // Async reset pulse between edges, no clock edge involved.
    #1 nRst = 1'b0; clear_model();
    sample("rst_pulse");
    #4 nRst = 1'b1;
    sample("rst_release");

    // Single write.
    @(negedge clk); aWrite = 2'd2; dataIn = 8'h56; load = 1'b1; a1 = 2'd3; a2 = 2'd2;
    @(posedge clk); model[2] = 8'h56;
    sample("wr_single");
    @(negedge clk); load = 1'b0;

    // Writes disabled.
    aWrite = 2'd1; dataIn = 8'hAA;
    repeat (3) @(posedge clk);
    @(negedge clk); a1 = 2'd1; a2 = 2'd2;
    sample("no_load");

    // Fill registers on consecutive edges, then sweep both ports.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); aWrite = reg_addr_t'(i); dataIn = reg_data_t'(8'h11 * (i + 1)); load = 1'b1;
      @(posedge clk); model[i] = dataIn;
    end
    @(negedge clk); load = 1'b0;
    sweep("fill");

    // Read-during-write: old value before the edge, new after.
    @(negedge clk); a1 = 2'd3; a2 = 2'd0; aWrite = 2'd3; dataIn = 8'h99; load = 1'b1;
    sample("rdw_before");
    @(posedge clk); model[3] = 8'h99;
    sample("rdw_after");
    @(negedge clk); load = 1'b0;
    a1 = 2'd2; a2 = 2'd3;
    sample("rdw_others");

    // Reset mid-operation with load high; hold across an edge.
    @(negedge clk); aWrite = 2'd0; dataIn = 8'hEE; load = 1'b1;
    #2 nRst = 1'b0; clear_model();
    sweep("rst_mid");
    @(posedge clk);
    a1 = 2'd0; a2 = 2'd0;
    sample("rst_hold_load");
    @(negedge clk); load = 1'b0; nRst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    sweep("post_rst");

    if (sb_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_leftover observed=%0d expected=0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/reg_file.md
Name: reg_file

Overview:
- Small general-purpose register file for the NH CPU datapath.
- 2**AddrBusWidth registers of DataBusWidth bits each.
- Two independent combinational read ports and one synchronous write port.
- Feeds ALU operands (out1/out2) and receives write-back data (dataIn).

Parameters:
- AddrBusWidth, 2, register address width; depth NREG = 2**AddrBusWidth (default 4 registers).
- DataBusWidth, 8, register/data width in bits.

Ports:
- clk  input  1  system clock; all register updates on rising edge.
- nRst  input  1  asynchronous active-low reset.
- a1  input  AddrBusWidth  read address, port 1.
- a2  input  AddrBusWidth  read address, port 2.
- aWrite  input  AddrBusWidth  write address.
- dataIn  input  DataBusWidth  write data.
- load  input  1  write enable, active high.
- out1  output  DataBusWidth  contents of register[a1].
- out2  output  DataBusWidth  contents of register[a2].

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-low (nRst).
- Reset:
  - nRst low clears every register to 0 immediately, independent of clk.
  - While nRst is low, out1 = out2 = 0 for any address.
  - Registers hold 0 while nRst stays low; load is ignored.
  - nRst deassertion may be asynchronous to clk; the first write is taken on the first rising edge with nRst high and load high.
- Write:
  - On rising clk with nRst high and load high: register[aWrite] <= dataIn.
  - Exactly one register changes per write; all others hold.
  - load low: no register changes, regardless of aWrite/dataIn.
- Read:
  - out1 = register[a1] and out2 = register[a2], purely combinational (zero-cycle latency from address change).
  - No internal read bypass: a read of the register being written returns the old value until the write edge, then the new value in the same cycle after the edge.
- Simultaneous events:
  - a1 == a2 is legal; both outputs show the same register.
  - Read and write to the same address in one cycle: old value before the edge, new value after.
- Register 0 is an ordinary writable register (not hardwired to zero).
- No X-propagation sources after reset; all addresses are in range by construction (full decode of AddrBusWidth bits).

Decomposition:
- Shared package nh_cpu_pkg:
  - constants ADDR_W = 2 and DATA_W = 8;
  - typedefs reg_addr_t and reg_data_t used by datapath blocks.
- One natural sub-module, reg_file_cell:
  - one DataBusWidth-bit register with async active-low clear and enable;
  - generated NREG times, with enable = load && (aWrite == index).
- Read muxes are inline in reg_file.

Test Plan:
1. Reset: drive a1=1, a2=2, load=0; pulse nRst low for 5 time units between clock edges -> out1 = out2 = 0x00 immediately on nRst falling, without a clock edge.
2. Single write: after reset set aWrite=2, dataIn=0x56, load=1 for one rising edge, then load=0 -> out2 (a2=2) = 0x56 right after that edge; out1 (a1=3) stays 0x00.
3. Write disabled: load=0, aWrite=1, dataIn=0xAA across several edges -> all registers remain unchanged (read a1=1 -> 0x00).
4. Fill and read back: write 0x11, 0x22, 0x33, 0x44 to registers 0..3 on consecutive edges; then sweep a1 and a2 over all addresses -> each port returns the matching value combinationally, including a1==a2.
5. Read-during-write: a1=3 holds 0x44; write 0x99 to register 3 -> out1 shows 0x44 up to the edge, 0x99 after it.
6. Reset mid-operation: assert nRst low between edges while load=1 with all registers loaded -> all outputs 0x00 at once; after release with load=0, registers stay 0x00.
